// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry elastic buffer with a registered, state-only in_ready
module pipe_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);
    logic [1:0]       c_q, c_d;
    logic [WIDTH-1:0] h_q, h_d, s_q;
    logic             push, pop, h_en, s_en, kill;
    assign in_ready  = c_q != 2'd2;
    assign out_valid = c_q != 2'd0;
    assign out_data  = h_q;
    assign count     = c_q;
    // handshake decode, register load enables and next occupancy
    always_comb begin
        push = in_valid & in_ready;
        pop  = out_valid & out_ready;
        kill = reset | flush;
        h_en = ~kill & ((c_q == 2'd0 & push) | (c_q == 2'd1 & push & pop) | (c_q == 2'd2 & pop));
        s_en = ~kill & c_q == 2'd1 & push & ~pop;
        h_d  = c_q == 2'd2 ? s_q : in_data;
        c_d  = kill ? 2'd0 : c_q + {1'b0, push} - {1'b0, pop};
    end
    // occupancy counter is the only reset state
    always_ff @(posedge clk) begin
        c_q <= c_d;
    end
    // data registers hold unless enabled; contents are don't-care when empty
    always_ff @(posedge clk) begin
        if (h_en) h_q <= h_d;
        if (s_en) s_q <= in_data;
    end
endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer: directed vectors, streaming sequence and random scoreboard
module tb_pipe_skid_buffer;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  count;
    int          n_vec = 0;
    int          n_bad = 0;

    pipe_skid_buffer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic [1:0]  ec;
        logic        ev;
        logic        er;
        logic [31:0] ed;
    } vec_t;

    vec_t tv[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] id, input logic o);
        reset = r; flush = f; in_valid = iv; in_data = id; out_ready = o;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic        p, d;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        //          rst fl iv data          or  cnt v  rdy data
        tv[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 32'h0};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 32'h0};
        tv[2]  = '{1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 2'd1, 1'b1, 1'b1, 32'hDEADBEEF};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 2'd0, 1'b0, 1'b1, 32'h0};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 32'hA,        1'b0, 2'd1, 1'b1, 1'b1, 32'hA};
        tv[5]  = '{1'b0, 1'b0, 1'b1, 32'hB,        1'b0, 2'd2, 1'b1, 1'b0, 32'hA};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 32'hC,        1'b0, 2'd2, 1'b1, 1'b0, 32'hA};
        tv[7]  = '{1'b0, 1'b0, 1'b1, 32'hC,        1'b1, 2'd1, 1'b1, 1'b1, 32'hB};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 32'hC,        1'b1, 2'd1, 1'b1, 1'b1, 32'hC};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 2'd0, 1'b0, 1'b1, 32'h0};
        tv[10] = '{1'b0, 1'b0, 1'b1, 32'h5,        1'b0, 2'd1, 1'b1, 1'b1, 32'h5};
        tv[11] = '{1'b0, 1'b0, 1'b1, 32'h6,        1'b1, 2'd1, 1'b1, 1'b1, 32'h6};
        tv[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 2'd0, 1'b0, 1'b1, 32'h0};
        tv[13] = '{1'b0, 1'b0, 1'b1, 32'h11,       1'b0, 2'd1, 1'b1, 1'b1, 32'h11};
        tv[14] = '{1'b0, 1'b0, 1'b1, 32'h22,       1'b0, 2'd2, 1'b1, 1'b0, 32'h11};
        tv[15] = '{1'b0, 1'b1, 1'b1, 32'h33,       1'b0, 2'd0, 1'b0, 1'b1, 32'h0};
        tv[16] = '{1'b0, 1'b0, 1'b1, 32'h44,       1'b0, 2'd1, 1'b1, 1'b1, 32'h44};
        tv[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 2'd0, 1'b0, 1'b1, 32'h0};
        tv[18] = '{1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 2'd1, 1'b1, 1'b1, 32'h1};
        tv[19] = '{1'b0, 1'b0, 1'b1, 32'h2,        1'b0, 2'd2, 1'b1, 1'b0, 32'h1};
        tv[20] = '{1'b1, 1'b0, 1'b1, 32'h3,        1'b1, 2'd0, 1'b0, 1'b1, 32'h0};
        tv[21] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 32'h0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 22; i++) begin
            drive(tv[i].rst, tv[i].fl, tv[i].iv, tv[i].id, tv[i].ordy);
            chk($sformatf("v%0d count", i), 32'(count), 32'(tv[i].ec));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tv[i].ev));
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tv[i].er));
            if (tv[i].ev) chk($sformatf("v%0d out_data", i), out_data, tv[i].ed);
        end
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'(i), 1'b1);
            chk($sformatf("stream%0d out_data", i), out_data, 32'(i));
            chk($sformatf("stream%0d count", i), 32'(count), 32'd1);
            chk($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("stream drain count", 32'(count), 32'd0);
        for (int i = 0; i < 1000; i++) begin
            chk("rnd count", 32'(count), 32'(q.size()));
            chk("rnd in_ready", 32'(in_ready), 32'(q.size() != 2));
            chk("rnd out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("rnd out_data", out_data, q[0]);
            reset = 1'b0;
            flush = $urandom_range(0, 99) < 3;
            in_valid = $urandom_range(0, 99) < 60;
            out_ready = $urandom_range(0, 99) < 55;
            in_data = $urandom;
            p = in_valid && q.size() < 2;
            d = out_ready && q.size() > 0;
            @(posedge clk);
            if (flush) q.delete();
            else begin
                if (d) void'(q.pop_front());
                if (p) q.push_back(in_data);
            end
            #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_skid_buffer.md
Name: pipe_skid_buffer

Overview:
- Two-entry elastic buffer between adjacent x86 pipeline stages.
- Consumes the upstream stage's latched bundle, for example the q outputs of that stage's pipeline register bank.
- Presents the bundle downstream with a valid/ready handshake and absorbs one cycle of downstream stall without a combinational ready path.
- Generates the load enables for its internal data registers, which hold their value when not loaded.

Parameters:
WIDTH, 32, bit width of the data bundle carried per entry

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
flush  input  1  synchronous pipeline flush (branch mispredict/exception); discards all entries
in_valid  input  1  upstream offers in_data this cycle
in_data  input  WIDTH  upstream data bundle
in_ready  output  1  buffer can accept a push this cycle
out_valid  output  1  head entry valid
out_data  output  WIDTH  head entry data
out_ready  input  1  downstream accepts the head this cycle
count  output  2  number of valid entries, 0..2

Behaviour:
- State: head register H, skid register S, count C.
- Data registers load only when their enable is asserted; otherwise they hold.
- Combinational outputs:
  - out_valid = (C != 0).
  - in_ready = (C != 2). It depends on state only; in_valid and out_ready do not feed it combinationally.
  - out_data = H.
  - count = C.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_valid while in_ready=0 is ignored and the data is not captured; upstream holds it.
  - out_ready while out_valid=0 is ignored.
- Latency: data pushed at edge N is on out_data with out_valid=1 after edge N. The minimum latency is 1 cycle; there is no flow-through.
- Throughput: one push and one pop per cycle are sustained at C=1.
- Transitions, evaluated at the clock edge, with reset and flush taking priority:
  - C=0, push: H<=in_data, C=1.
  - C=1, push, no pop: S<=in_data, C=2.
  - C=1, pop, no push: C=0. H holds a stale value, don't-care.
  - C=1, push and pop: H<=in_data, C=1.
  - C=2, pop: H<=S, C=1. A push is impossible because in_ready=0.
  - C=2, no pop: hold.
  - No push and no pop: hold.
- Ordering: strict FIFO. S is always younger than H.
- Reset (synchronous):
  - On the next edge C<=0, so out_valid=0, in_ready=1, count=0.
  - H and S are not required to be reset; out_data is don't-care while out_valid=0. The bench shall not check out_data when out_valid=0.
  - Reset asserted mid-transfer discards all entries; any push or pop offered that cycle is dropped.
- Flush:
  - Same effect as reset on C; priority is reset > flush > push/pop.
  - A push offered in the flush cycle is discarded.
  - A pop in the flush cycle is treated as consumed by downstream. Downstream also sees flush and must drop it.
- Invariants:
  - C never reaches 3; underflow never occurs.
  - H and S do not change when their enable is low.
- Fully synthesizable. There is no async path from reset.

Test Plan:
- Reset, then an idle cycle -> count=0, out_valid=0, in_ready=1. Apply in_valid=1, in_data=0xDEADBEEF with out_ready=1 -> the next cycle shows out_valid=1, out_data=0xDEADBEEF, count=1.
- Streaming: push 0x1,0x2,...,0x10 on consecutive cycles with out_ready=1 every cycle -> out_data sequence 0x1..0x10 at one per cycle, one cycle behind input; count stays 1; in_ready never drops.
- Stall and skid: push 0xA then 0xB with out_ready=0 -> count=2, in_ready=0, out_data=0xA. Offer 0xC while stalled -> not accepted. Raise out_ready for 3 cycles with 0xC held -> outputs 0xA, 0xB, 0xC in order; 0xC is pushed the cycle in_ready returns.
- Simultaneous push and pop at C=1: H=0x5, push 0x6 with out_ready=1 -> the next cycle shows out_data=0x6, count=1, no dropped or duplicated entry.
- Flush with C=2 (0x11, 0x22) plus a concurrent push of 0x33 -> the next cycle shows count=0, out_valid=0, in_ready=1. A subsequent push of 0x44 is the next value out.
- Reset asserted while C=2 and in_valid=1 -> the next cycle shows count=0. After deassert, a random push/pop scoreboard over 1000 cycles reports no loss, duplication or reordering.
